// File: rtl/cache_axi_refill.sv
// AXI4 refill / write-back engine for one cache: an optional dirty-victim INCR write burst,
// then an INCR read burst returned on cacheline_new with a one-cycle refresh pulse.
module cache_axi_refill #(
  parameter int         CACHELINE_WIDTH = 512,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss,
  input  logic [31:0]                axi_raddr,
  input  logic                       write_back,
  input  logic [31:0]                axi_waddr,
  input  logic [CACHELINE_WIDTH-1:0] cacheline_old,
  output logic                       refresh,
  output logic [CACHELINE_WIDTH-1:0] cacheline_new,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [3:0]                 awid,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  // state | meaning
  // IDLE  | waiting for miss; latches addresses and victim line
  // AW    | write address presented
  // W     | victim words streamed, wlast on the final word
  // B     | waiting for the write response
  // AR    | read address presented
  // R     | refill words captured into cacheline_new
  // DONE  | refresh pulse
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  localparam int WORDS = CACHELINE_WIDTH / 32;
  localparam int OFF   = $clog2(CACHELINE_WIDTH / 8);
  localparam int BW    = $clog2(WORDS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
  localparam logic [BW-1:0] BEAT_SAT  = BW'(WORDS);

  state_t                     state, state_nxt;
  logic [BW-1:0]              beat;
  logic [CACHELINE_WIDTH-1:0] victim;
  logic                       rearm;
  logic                       accept;
  logic                       unused_bits;

  // rearm blocks a miss that is still high right after refresh from starting a second refill
  assign accept = (state == S_IDLE) && miss && !rearm;

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'(WORDS - 1);
  assign awlen   = 8'(WORDS - 1);
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = wvalid && (beat == LAST_BEAT);
  assign wstrb   = wvalid ? 4'hf : 4'h0;

  assign unused_bits = ^{rresp, bresp, axi_raddr[OFF-1:0], axi_waddr[OFF-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    refresh   = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = write_back ? S_AW : S_AR;
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        if (wready && beat == LAST_BEAT) state_nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = S_DONE;
      end
      S_DONE: begin
        refresh   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < WORDS; i++)
      if (beat == BW'(i)) wdata = victim[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat          <= '0;
      victim        <= '0;
      araddr        <= '0;
      awaddr        <= '0;
      cacheline_new <= '0;
      rearm         <= 1'b0;
    end else begin
      if (accept) begin
        araddr <= {axi_raddr[31:OFF], {OFF{1'b0}}};
        awaddr <= {axi_waddr[31:OFF], {OFF{1'b0}}};
        victim <= cacheline_old;
        beat   <= '0;
      end
      if (wvalid && wready)
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      // rlast ends the burst; a beat count past the line saturates and writes nothing
      if (rvalid && rready) begin
        for (int i = 0; i < WORDS; i++)
          if (beat == BW'(i)) cacheline_new[i*32 +: 32] <= rdata;
        if (beat != BEAT_SAT) beat <= beat + 1'b1;
      end
      if (state == S_DONE) rearm <= 1'b1;
      else if (!miss)      rearm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_axi_refill.sv
// Self-checking bench for cache_axi_refill: a cycle-level AXI slave plus a line-level
// reference (expected line = words the slave returned, expected W data = victim words).
`timescale 1ns/1ps
module tb_cache_axi_refill;
  localparam int CLW   = 512;
  localparam int WORDS = CLW / 32;

  logic           clk = 1'b0, rst = 1'b0;
  logic           miss = 1'b0, write_back = 1'b0;
  logic [31:0]    axi_raddr = '0, axi_waddr = '0;
  logic [CLW-1:0] cacheline_old = '0;
  logic           refresh;
  logic [CLW-1:0] cacheline_new;
  logic [3:0]     arid, awid;
  logic [31:0]    araddr, awaddr, wdata;
  logic [7:0]     arlen, awlen;
  logic [2:0]     arsize, awsize;
  logic [1:0]     arburst, awburst;
  logic           arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]     wstrb;
  logic           arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, awready = 1'b0;
  logic           wready = 1'b0, bvalid = 1'b0;
  logic [31:0]    rdata = '0;
  logic [1:0]     rresp = '0, bresp = '0;

  cache_axi_refill #(.CACHELINE_WIDTH(CLW), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .miss(miss), .axi_raddr(axi_raddr), .write_back(write_back),
    .axi_waddr(axi_waddr), .cacheline_old(cacheline_old), .refresh(refresh),
    .cacheline_new(cacheline_new), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [31:0]    rd_words [WORDS];
  logic [31:0]    w_seen [$];
  bit             wlast_seen [$];
  int             aw_cnt, ar_cnt, b_cnt, r_beats, refresh_cnt, refresh_cyc, proto_err;
  logic [31:0]    aw_addr_seen, ar_addr_seen;
  logic [7:0]     aw_len_seen, ar_len_seen;
  logic [CLW-1:0] line_at_refresh, line_at_end;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'(CLW / 8 - 1);
  endfunction

  function automatic logic [CLW-1:0] words_to_line();
    logic [CLW-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = rd_words[i];
    return l;
  endfunction

  function automatic logic [CLW-1:0] rand_line();
    logic [CLW-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic fill_random_words();
    for (int i = 0; i < WORDS; i++) rd_words[i] = $urandom;
  endtask

  // Acts as cache and AXI slave, one decision per negedge; handshakes land on the next posedge.
  task automatic run_refill(input bit wb, input logic [31:0] raddr, input logic [31:0] waddr,
                            input logic [CLW-1:0] old, input bit stall, input logic [1:0] rr,
                            input int hold, input int abort_rbeat);
    bit r_open, r_hold, b_owed, p_aw, p_w, p_ar, p_wlast;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    r_open = 0; r_hold = 0; b_owed = 0; p_aw = 0; p_w = 0; p_ar = 0; p_wlast = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0;
    aw_cnt = 0; ar_cnt = 0; b_cnt = 0; r_beats = 0; refresh_cnt = 0; refresh_cyc = -1;
    proto_err = 0; w_seen.delete(); wlast_seen.delete();
    miss = 1'b1; write_back = wb; axi_raddr = raddr; axi_waddr = waddr; cacheline_old = old;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (abort_rbeat >= 0 && r_beats == abort_rbeat) return;
      axi_raddr = $urandom; axi_waddr = $urandom; cacheline_old = ~old;
      if (p_aw && (awvalid !== 1'b1 || awaddr !== p_awaddr)) proto_err++;
      if (p_w && (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast)) proto_err++;
      if (p_ar && (arvalid !== 1'b1 || araddr !== p_araddr)) proto_err++;
      if (wvalid && wstrb !== 4'hf) proto_err++;
      if ((wvalid || awvalid || bready) && (arvalid || rready)) proto_err++;
      if (refresh === 1'b1) begin
        refresh_cnt++;
        if (refresh_cnt == 1) begin refresh_cyc = cyc; line_at_refresh = cacheline_new; end
      end
      if (refresh_cnt > 0 && cyc > refresh_cyc + hold) miss = 1'b0;
      if (refresh_cnt > 0 && cyc >= refresh_cyc + hold + 12) break;
      // R
      if (r_open && r_beats < WORDS) begin
        rvalid = r_hold ? 1'b1 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        rdata  = rvalid ? rd_words[r_beats] : $urandom;
        rlast  = rvalid && (r_beats == WORDS - 1);
        rresp  = rvalid ? rr : 2'($urandom_range(0, 3));
        if (rvalid && rready) begin r_beats++; r_hold = 0; end
        else r_hold = rvalid;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rdata = $urandom;
      end
      // B
      if (b_owed) begin
        bvalid = 1'b1; bresp = stall ? 2'($urandom_range(0, 3)) : 2'b00;
        if (bready) begin b_owed = 0; b_cnt++; end
      end else bvalid = 1'b0;
      // AR
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arvalid && arready) begin
        ar_cnt++; ar_addr_seen = araddr; ar_len_seen = arlen;
        if (wb && b_cnt == 0) proto_err++;
        r_open = 1; r_beats = 0;
      end
      p_ar = arvalid && !arready; p_araddr = araddr;
      // W
      wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid && wready) begin
        w_seen.push_back(wdata); wlast_seen.push_back(wlast);
        if (aw_cnt == 0) proto_err++;
        if (wlast) b_owed = 1;
      end
      p_w = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
      // AW
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (awvalid && awready) begin aw_cnt++; aw_addr_seen = awaddr; aw_len_seen = awlen; end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
    end
    line_at_end = cacheline_new;
    miss = 1'b0; rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (refresh !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL reset_valids: refresh=%b arvalid=%b awvalid=%b, want 0", refresh, arvalid, awvalid); end
    checks++; if (wvalid !== 1'b0 || rready !== 1'b0 || bready !== 1'b0 || wlast !== 1'b0) begin errors++; $display("FAIL reset_handshake: wvalid=%b rready=%b bready=%b wlast=%b, want 0", wvalid, rready, bready, wlast); end
    checks++; if (cacheline_new !== '0 || araddr !== 32'h0 || awaddr !== 32'h0) begin errors++; $display("FAIL reset_data: araddr=%h awaddr=%h line_nonzero=%b", araddr, awaddr, |cacheline_new); end
    checks++; if (arlen !== 8'd15 || awlen !== 8'd15 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0) begin errors++; $display("FAIL const_ctrl: arlen=%0d awlen=%0d arsize=%b arburst=%b arid=%h", arlen, awlen, arsize, arburst, arid); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_miss();
    logic [CLW-1:0] exp;
    for (int i = 0; i < WORDS; i++) rd_words[i] = 32'(i);
    exp = words_to_line();
    run_refill(0, 32'h1000_0044, 32'h0, rand_line(), 0, 2'b00, 0, -1);
    checks++; if (ar_addr_seen !== 32'h1000_0040) begin errors++; $display("FAIL clean_araddr: got %h want 10000040", ar_addr_seen); end
    checks++; if (ar_len_seen !== 8'd15) begin errors++; $display("FAIL clean_arlen: got %0d want 15", ar_len_seen); end
    checks++; if (refresh_cyc != 18 || refresh_cnt != 1) begin errors++; $display("FAIL clean_latency: refresh at %0d count %0d, want 18 / 1", refresh_cyc, refresh_cnt); end
    checks++; if (line_at_refresh !== exp) begin errors++; $display("FAIL clean_line: got %h want %h", line_at_refresh, exp); end
    checks++; if (aw_cnt != 0 || w_seen.size() != 0 || ar_cnt != 1) begin errors++; $display("FAIL clean_bursts: aw=%0d w=%0d ar=%0d, want 0/0/1", aw_cnt, w_seen.size(), ar_cnt); end
    checks++; if (line_at_end !== exp || proto_err != 0) begin errors++; $display("FAIL clean_hold: line_held=%b proto_err=%0d", line_at_end === exp, proto_err); end
  endtask

  task automatic test_dirty_miss();
    logic [CLW-1:0] old, exp;
    for (int i = 0; i < WORDS; i++) old[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    fill_random_words();
    exp = words_to_line();
    run_refill(1, 32'h3000_1234, 32'h2000_0000, old, 0, 2'b00, 0, -1);
    checks++; if (aw_cnt != 1 || aw_addr_seen !== 32'h2000_0000 || aw_len_seen !== 8'd15) begin errors++; $display("FAIL dirty_aw: cnt=%0d addr=%h len=%0d", aw_cnt, aw_addr_seen, aw_len_seen); end
    checks++; if (w_seen.size() != WORDS) begin errors++; $display("FAIL dirty_wcount: got %0d want %0d", w_seen.size(), WORDS); end
    for (int i = 0; i < w_seen.size() && i < WORDS; i++) begin
      checks++; if (w_seen[i] !== old[i*32 +: 32] || wlast_seen[i] != (i == WORDS - 1)) begin errors++; $display("FAIL dirty_wbeat%0d: data=%h wlast=%b want %h/%b", i, w_seen[i], wlast_seen[i], old[i*32 +: 32], i == WORDS - 1); end
    end
    checks++; if (b_cnt != 1 || ar_cnt != 1 || proto_err != 0) begin errors++; $display("FAIL dirty_order: b=%0d ar=%0d proto_err=%0d", b_cnt, ar_cnt, proto_err); end
    checks++; if (ar_addr_seen !== 32'h3000_1200) begin errors++; $display("FAIL dirty_araddr: got %h want 30001200", ar_addr_seen); end
    checks++; if (refresh_cyc != 36 || refresh_cnt != 1) begin errors++; $display("FAIL dirty_latency: refresh at %0d count %0d, want 36 / 1", refresh_cyc, refresh_cnt); end
    checks++; if (line_at_refresh !== exp) begin errors++; $display("FAIL dirty_line: got %h want %h", line_at_refresh, exp); end
  endtask

  task automatic test_back_pressure();
    logic [CLW-1:0] old, exp, zero_wait;
    logic [31:0] ra, wa;
    for (int n = 0; n < 3; n++) begin
      fill_random_words();
      exp = words_to_line(); old = rand_line();
      ra = $urandom; wa = $urandom;
      run_refill(1, ra, wa, old, 0, 2'b00, 0, -1);
      zero_wait = line_at_refresh;
      run_refill(1, ra, wa, old, 1, 2'b00, 0, -1);
      checks++; if (line_at_refresh !== zero_wait || line_at_refresh !== exp) begin errors++; $display("FAIL bp_line%0d: got %h want %h", n, line_at_refresh, exp); end
      checks++; if (proto_err != 0 || refresh_cnt != 1 || ar_cnt != 1) begin errors++; $display("FAIL bp_proto%0d: proto_err=%0d refresh=%0d ar=%0d", n, proto_err, refresh_cnt, ar_cnt); end
      checks++; if (w_seen.size() != WORDS || aw_addr_seen !== align(wa) || ar_addr_seen !== align(ra)) begin errors++; $display("FAIL bp_addr%0d: w=%0d aw=%h ar=%h want %h %h", n, w_seen.size(), aw_addr_seen, ar_addr_seen, align(wa), align(ra)); end
      for (int i = 0; i < w_seen.size() && i < WORDS; i++) begin
        checks++; if (w_seen[i] !== old[i*32 +: 32]) begin errors++; $display("FAIL bp_wdata%0d_%0d: got %h want %h", n, i, w_seen[i], old[i*32 +: 32]); end
      end
    end
  endtask

  task automatic test_held_miss();
    fill_random_words();
    run_refill(0, $urandom, 32'h0, rand_line(), 0, 2'b00, 2, -1);
    checks++; if (ar_cnt != 1 || refresh_cnt != 1) begin errors++; $display("FAIL held_miss: ar=%0d refresh=%0d, want 1/1", ar_cnt, refresh_cnt); end
    checks++; if (line_at_end !== words_to_line()) begin errors++; $display("FAIL held_line: got %h want %h", line_at_end, words_to_line()); end
  endtask

  task automatic test_reset_mid_burst();
    fill_random_words();
    run_refill(0, 32'h4000_0000, 32'h0, rand_line(), 0, 2'b00, 0, 7);
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL mid_in_r: rready=%b want 1", rready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rready !== 1'b0 || arvalid !== 1'b0 || refresh !== 1'b0) begin errors++; $display("FAIL mid_async: rready=%b arvalid=%b refresh=%b, want 0", rready, arvalid, refresh); end
    checks++; if (cacheline_new !== '0 || araddr !== 32'h0) begin errors++; $display("FAIL mid_clear: araddr=%h line_nonzero=%b", araddr, |cacheline_new); end
    miss = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill_random_words();
    run_refill(0, 32'h5000_0080, 32'h0, rand_line(), 0, 2'b00, 0, -1);
    checks++; if (refresh_cyc != 18 || line_at_refresh !== words_to_line()) begin errors++; $display("FAIL mid_recover: refresh at %0d line_ok=%b", refresh_cyc, line_at_refresh === words_to_line()); end
  endtask

  task automatic test_error_resp();
    fill_random_words();
    run_refill(0, $urandom, 32'h0, rand_line(), 0, 2'b10, 0, -1);
    checks++; if (line_at_refresh !== words_to_line()) begin errors++; $display("FAIL err_line: got %h want %h", line_at_refresh, words_to_line()); end
    checks++; if (refresh_cnt != 1) begin errors++; $display("FAIL err_refresh: count %0d want 1", refresh_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [CLW-1:0] prev;
    logic [31:0] ra, wa;
    bit wb, st;
    for (int n = 0; n < 4; n++) begin
      prev = cacheline_new;
      fill_random_words();
      ra = $urandom; wa = $urandom; wb = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
      checks++; if (cacheline_new !== prev) begin errors++; $display("FAIL b2b_idle_hold%0d: line changed while idle", n); end
      run_refill(wb, ra, wa, rand_line(), st, 2'($urandom_range(0, 3)), 0, -1);
      checks++; if (line_at_refresh !== words_to_line() || refresh_cnt != 1) begin errors++; $display("FAIL b2b_line%0d: refresh=%0d got %h want %h", n, refresh_cnt, line_at_refresh, words_to_line()); end
      checks++; if (ar_addr_seen !== align(ra) || aw_cnt != int'(wb) || (wb && aw_addr_seen !== align(wa))) begin errors++; $display("FAIL b2b_addr%0d: ar=%h aw=%h awcnt=%0d want %h %h %0d", n, ar_addr_seen, aw_addr_seen, aw_cnt, align(ra), align(wa), wb); end
      checks++; if (proto_err != 0 || w_seen.size() != (wb ? WORDS : 0)) begin errors++; $display("FAIL b2b_proto%0d: proto_err=%0d wbeats=%0d", n, proto_err, w_seen.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_back_pressure();
    test_held_miss();
    test_reset_mid_burst();
    test_error_resp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_axi_refill.md
# cache_axi_refill

AXI4 master-side refill/write-back engine that serves one cache (icache or dcache) of the generic cache module. It accepts the cache's miss request (`miss`, `axi_raddr`, `write_back`, `axi_waddr`, `cacheline_old`) and writes the dirty victim line back as an INCR burst. It then fetches the new line as an INCR burst and returns it on `cacheline_new` with a one-cycle `refresh` pulse. One instance sits between each cache tag/data pair and the AXI interconnect.

## Interface
- `CACHELINE_WIDTH`, default 512: line size in bits; multiple of 32, 64..8192. `WORDS = CACHELINE_WIDTH/32`.
- `AXI_ID`, default 4'd0: constant ID driven on `arid` and `awid`.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `miss` in 1: the cache requests a refill; held until `refresh`.
- `axi_raddr` in 32: refill line address; the engine forces low `log2(CACHELINE_WIDTH/8)` bits to 0.
- `write_back` in 1: the victim is dirty; sampled together with `miss`.
- `axi_waddr` in 32: victim line address, aligned like `axi_raddr`.
- `cacheline_old` in CACHELINE_WIDTH: victim data, word i = bits [32i+31:32i].
- `refresh` out 1: one-cycle pulse; the cache installs `cacheline_new`.
- `cacheline_new` out CACHELINE_WIDTH: refilled line; valid when `refresh`=1 and held until the next refill's first R beat.
- `arid`, `awid` out 4: = `AXI_ID`.
- `araddr`, `awaddr` out 32: latched aligned addresses.
- `arlen`, `awlen` out 8: constant WORDS-1. `arsize`/`awsize` out 3 = 3'b010. `arburst`/`awburst` out 2 = 2'b01.
- `arvalid` out 1, `arready` in 1.
- `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4 (= 4'hf while `wvalid`), `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- States: IDLE, AW, W, B, AR, R, DONE. One-hot or binary encoding; no other states.
- IDLE, `miss`=1: latch `araddr`, `awaddr` and the victim buffer (`cacheline_old`). Clear the beat counter. Go to AW if `write_back`=1, otherwise AR.
- AW: `awvalid`=1 until `awready`, then W. Address and control stay stable while valid.
- W: `wvalid`=1 and `wdata` = victim word[beat]. The beat increments on `wvalid&wready`. `wlast`=1 when beat==WORDS-1. The handshake on the last beat goes to B and clears the beat counter.
- B: `bready`=1; `bvalid` goes to AR.
- AR: `arvalid`=1 until `arready`, then R.
- R: `rready`=1. On `rvalid&rready`, write `cacheline_new` word[beat] = `rdata` and increment the beat. The handshake with `rlast`=1 goes to DONE. `rlast` is authoritative; a beat count beyond WORDS-1 must not write outside the line.
- DONE: `refresh`=1 for exactly one cycle, then IDLE.
- `rresp` and `bresp` are ignored; non-OKAY data is installed as received.
- The cache drops `miss` in the cycle after `refresh`. IDLE samples `miss` only in IDLE, so a held `miss` cannot start a second refill during DONE.
- A new `miss` is not accepted while busy; the inputs are don't-care outside IDLE.

## Timing
- Reset values: all valid/ready outputs 0, `refresh` 0, `wlast` 0, `cacheline_new` 0, addresses 0, state IDLE, beat 0.
- An asynchronous reset at any point, including mid-burst, returns everything to the reset values immediately. The in-flight transaction is abandoned, since the interconnect is reset together with the engine.
- Clean refill latency, with `arready`=1 and `rvalid`=1 every cycle from the cycle after AR:
  - Cycle 0: `miss` sampled in IDLE.
  - Cycle 1: AR handshake.
  - Cycles 2..WORDS+1: R beats.
  - Cycle WORDS+2: `refresh`. For WORDS=16 this is cycle 18.
- Dirty refill latency with an always-ready slave and `bvalid` in the cycle after `wlast`: an additional WORDS+2 cycles (AW, W beats, B).
- Valid signals never drop without a handshake. Back-pressure from `*ready`=0 stalls indefinitely with no timeout.
- Read and write bursts never overlap. AW precedes W; W is not issued before the AW handshake.

## Test plan
- Clean miss:
  - Stimulus: `write_back`=0, `axi_raddr`=32'h1000_0044, zero-wait slave returning rdata=beat index.
  - Required: `araddr`=32'h1000_0040, `arlen`=15, `refresh` at cycle 18, `cacheline_new` word i = i.
- Dirty miss:
  - Stimulus: `write_back`=1, `axi_waddr`=32'h2000_0000, `cacheline_old` word i = 32'hA000_0000+i.
  - Required: 16 W beats carrying that data, `wlast` only on beat 15, AR only after B, then `refresh`.
- Back-pressure:
  - Stimulus: `awready`/`wready`/`arready`/`rvalid` toggled pseudo-randomly.
  - Required: valids and payloads stable while stalled; final line bit-identical to the zero-wait result.
- Held miss:
  - Stimulus: `miss` held for 2 cycles after `refresh`.
  - Required: exactly one AR burst.
- Reset mid-burst:
  - Stimulus: `rst`=0 at R beat 7.
  - Required: `rready`, `arvalid` and `refresh` all 0 asynchronously; after release, a new `miss` completes a normal refill.
- Error response:
  - Stimulus: `rresp`=2'b10 on all beats.
  - Required: data installed anyway and `refresh` still pulses once.
